// File: rtl/sliding_window_gen_pkg.sv
// Shared types, default constants and helpers for the sliding window generator.
package sliding_window_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_K     = 3;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  // Counter widths for the default image geometry.
  localparam int DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int DEF_ROW_W = $clog2(DEF_IMG_H);

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  // Flattened window slot of row r (0 = oldest line), column c (0 = oldest column).
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// One image line of pixel storage: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle return the old pixel,
// which is exactly the pixel one line above the one being written.
module line_buffer #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [PIX_W-1:0]         wr_data,
  output logic [PIX_W-1:0]         rd_data
);

  logic [PIX_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  // Store the incoming pixel once per accepted input.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster-order pixel stream to KxK window generator with valid/ready on both sides.
// K-1 chained line buffers supply the upper rows of each new window column;
// a KxK shift register holds the window itself.
module sliding_window_gen
  import sliding_window_pkg::*;
#(
  parameter  int PIX_W = DEF_PIX_W,
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  parameter  int K     = DEF_K,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sof,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*K*PIX_W-1:0] window,
  output logic [COL_W-1:0]     col,
  output logic [ROW_W-1:0]     row,
  output logic                 frame_done
);

  logic             accept;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic             pos_last_col;
  logic             pos_last_row;
  logic             pos_in_win;

  logic [PIX_W-1:0] lb_wr   [K-1];
  logic [PIX_W-1:0] lb_rd   [K-1];
  logic [PIX_W-1:0] col_vec [K];
  logic [PIX_W-1:0] win_q   [K][K];

  // A stalled window blocks new input; a draining one lets the next pixel in.
  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  // sof resynchronises the position of the pixel that carries it.
  assign pos_col      = sof ? '0 : cur_col;
  assign pos_row      = sof ? '0 : cur_row;
  assign pos_last_col = (pos_col == COL_W'(IMG_W - 1));
  assign pos_last_row = (pos_row == ROW_W'(IMG_H - 1));
  assign pos_in_win   = (pos_row >= ROW_W'(K - 1)) && (pos_col >= COL_W'(K - 1));

  // Buffer 0 holds the previous line, buffer j the line j+1 above the current one.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_first
      assign lb_wr[j] = pixel;
    end else begin : g_next
      assign lb_wr[j] = lb_rd[j-1];
    end

    line_buffer #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W)
    ) u_lb (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (pos_col),
      .wr_data (lb_wr[j]),
      .rd_data (lb_rd[j])
    );

    assign col_vec[K-2-j] = lb_rd[j];
  end

  assign col_vec[K-1] = pixel;

  // Track the raster position of the next pixel, wrapping at line and frame ends.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (accept) begin
      if (pos_last_col) begin
        cur_col <= '0;
        cur_row <= pos_last_row ? '0 : pos_row + 1'b1;
      end else begin
        cur_col <= pos_col + 1'b1;
        cur_row <= pos_row;
      end
    end
  end

  // Shift the window left by one column and load the new column on every accept.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_vec[r];
      end
    end
  end

  // Flatten the window with the oldest row and column in the lowest slots.
  always_comb begin
    window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        window[win_idx(r, c, K)*PIX_W +: PIX_W] = win_q[r][c];
  end

  // Output valid, window position and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      out_valid  <= 1'b0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && pos_last_col && pos_last_row;
      if (accept) begin
        out_valid <= pos_in_win;
        if (pos_in_win) begin
          col <= pos_col;
          row <= pos_row;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Self-checking bench: a 3x3/4x4 instance driven by randomised streams and a
// 5x5/8x6 instance for the parameter sweep, both checked against an image model.
module tb_sliding_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: K=3, 4x4 image, 8-bit pixels
  logic        a_rst = 1'b1, a_sof = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [7:0]  a_pixel = '0;
  logic        a_in_ready, a_out_valid, a_frame_done;
  logic [71:0] a_window;
  logic [1:0]  a_col, a_row;

  sliding_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .K(3)) dut_a (
    .clk(clk), .n_rst(a_rst), .sof(a_sof), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pixel(a_pixel), .out_valid(a_out_valid), .out_ready(a_out_ready), .window(a_window),
    .col(a_col), .row(a_row), .frame_done(a_frame_done));

  // Instance B: K=5, 8x6 image, 10-bit pixels
  logic         b_rst = 1'b1, b_sof = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [9:0]   b_pixel = '0;
  logic         b_in_ready, b_out_valid, b_frame_done;
  logic [249:0] b_window;
  logic [2:0]   b_col, b_row;

  sliding_window_gen #(.PIX_W(10), .IMG_W(8), .IMG_H(6), .K(5)) dut_b (
    .clk(clk), .n_rst(b_rst), .sof(b_sof), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pixel(b_pixel), .out_valid(b_out_valid), .out_ready(b_out_ready), .window(b_window),
    .col(b_col), .row(b_row), .frame_done(b_frame_done));

  int passed = 0;
  int total  = 0;

  // Stimulus for instance A and its reference model state
  int stim_pix[$];
  bit stim_sof[$];

  typedef struct {
    logic [71:0] win;
    int          r;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   img[4][4];
  int   mr, mc;
  bit   exp_fd;
  int   win_count, fd_count;

  task automatic model_reset();
    mr = 0; mc = 0; exp_fd = 0;
    exp_q.delete();
  endtask

  task automatic stim_frame(input int base, input bit with_sof, input bit rnd);
    for (int i = 0; i < 16; i++) begin
      stim_pix.push_back(rnd ? int'($urandom_range(0, 255)) : base + i);
      stim_sof.push_back(with_sof && i == 0);
    end
  endtask

  // mode 0: always ready; 1: 5-cycle stall after first window; 2: random valid/ready
  task automatic run_stream(input int mode);
    int   idx = 0, cyc = 0, stall_left = 0;
    bit   first_seen = 0, stalled_prev = 0, acc, xfer;
    logic [75:0] held = '0;
    exp_t e;
    win_count = 0; fd_count = 0;
    while (idx < stim_pix.size() || exp_q.size() > 0) begin
      a_in_valid = (idx < stim_pix.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
      a_pixel    = a_in_valid ? 8'(stim_pix[idx]) : 8'h00;
      a_sof      = a_in_valid && stim_sof[idx];
      if (mode == 1 && a_out_valid && !first_seen) begin
        first_seen = 1; stall_left = 5;
      end
      if (mode == 1 && stall_left > 0) begin
        a_out_ready = 1'b0; stall_left--;
      end else if (mode == 2) a_out_ready = ($urandom_range(0, 2) != 0);
      else a_out_ready = 1'b1;
      #1;
      acc  = a_in_valid && a_in_ready;
      xfer = a_out_valid && a_out_ready;
      total++;
      if (a_in_ready !== (a_out_ready || !a_out_valid))
        $display("FAIL in_ready: got %b out_valid=%b out_ready=%b", a_in_ready, a_out_valid, a_out_ready);
      else passed++;
      if (stalled_prev) begin
        total++;
        if ({a_window, a_row, a_col} !== held)
          $display("FAIL stall_hold: got %h held %h", {a_window, a_row, a_col}, held);
        else passed++;
      end
      stalled_prev = a_out_valid && !a_out_ready;
      if (stalled_prev) held = {a_window, a_row, a_col};
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL window_a: got unexpected window %h at r%0d c%0d", a_window, a_row, a_col);
        end else begin
          e = exp_q.pop_front();
          if (a_window !== e.win || a_row !== 2'(e.r) || a_col !== 2'(e.c))
            $display("FAIL window_a: got %h r%0d c%0d exp %h r%0d c%0d", a_window, a_row, a_col, e.win, e.r, e.c);
          else passed++;
        end
        win_count++;
      end
      exp_fd = 0;
      if (acc) begin
        if (stim_sof[idx]) begin mr = 0; mc = 0; end
        img[mr][mc] = stim_pix[idx];
        if (mr >= 2 && mc >= 2) begin
          e.win = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.win[(r*3+c)*8 +: 8] = 8'(img[mr-2+r][mc-2+c]);
          e.r = mr; e.c = mc;
          exp_q.push_back(e);
        end
        exp_fd = (mr == 3 && mc == 3);
        mc++;
        if (mc == 4) begin mc = 0; mr = (mr + 1) % 4; end
        idx++;
      end
      @(negedge clk);
      cyc++;
      total++;
      if (a_out_valid !== (exp_q.size() > 0))
        $display("FAIL out_valid_a: got %b exp %b", a_out_valid, exp_q.size() > 0);
      else passed++;
      total++;
      if (a_frame_done !== exp_fd)
        $display("FAIL frame_done_a: got %b exp %b", a_frame_done, exp_fd);
      else passed++;
      if (a_frame_done === 1'b1) fd_count++;
      if (cyc > 2000) begin
        total++;
        $display("FAIL stream_timeout: got %0d cycles exp <= 2000", cyc);
        break;
      end
    end
    a_in_valid = 1'b0; a_sof = 1'b0; a_out_ready = 1'b1;
    stim_pix.delete(); stim_sof.delete();
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (a_out_valid !== 1'b0 || a_frame_done !== 1'b0 || a_window !== '0 || a_row !== '0 || a_col !== '0 || a_in_ready !== 1'b1)
      $display("FAIL reset_a: got v=%b fd=%b win=%h r=%0d c=%0d rdy=%b exp all zero, rdy=1",
               a_out_valid, a_frame_done, a_window, a_row, a_col, a_in_ready);
    else passed++;
    total++;
    if (b_out_valid !== 1'b0 || b_frame_done !== 1'b0 || b_window !== '0 || b_row !== '0 || b_col !== '0)
      $display("FAIL reset_b: got v=%b fd=%b r=%0d c=%0d exp all zero", b_out_valid, b_frame_done, b_row, b_col);
    else passed++;
    a_rst = 1'b0; b_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    stim_frame(0, 1, 0);
    run_stream(0);
    total++;
    if (win_count !== 4) $display("FAIL basic_count: got %0d exp 4", win_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    stim_frame(0, 1, 0);
    run_stream(1);
    total++;
    if (win_count !== 4) $display("FAIL backpressure_count: got %0d exp 4", win_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    stim_frame(0, 1, 0);
    stim_frame(100, 0, 0);
    run_stream(0);
    total++;
    if (win_count !== 8 || fd_count !== 2)
      $display("FAIL frame_wrap: got windows=%0d pulses=%0d exp 8 and 2", win_count, fd_count);
    else passed++;
  endtask

  task automatic test_mid_sof();
    for (int i = 0; i < 22; i++) begin
      stim_pix.push_back(i);
      stim_sof.push_back(i == 0 || i == 6);
    end
    run_stream(0);
    total++;
    if (win_count !== 4) $display("FAIL mid_sof_count: got %0d exp 4", win_count);
    else passed++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) stim_frame(0, f == 0, 1);
    run_stream(2);
    total++;
    if (win_count !== 12 || fd_count !== 3)
      $display("FAIL random_count: got windows=%0d pulses=%0d exp 12 and 3", win_count, fd_count);
    else passed++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) begin
      stim_pix.push_back(i);
      stim_sof.push_back(i == 0);
    end
    run_stream(0);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    total++;
    if (a_out_valid !== 1'b0 || a_frame_done !== 1'b0 || a_row !== '0 || a_col !== '0)
      $display("FAIL mid_reset: got v=%b fd=%b r=%0d c=%0d exp 0 0 0 0", a_out_valid, a_frame_done, a_row, a_col);
    else passed++;
    model_reset();
    stim_frame(0, 0, 0);
    run_stream(0);
    total++;
    if (win_count !== 4) $display("FAIL mid_reset_count: got %0d exp 4", win_count);
    else passed++;
  endtask

  task automatic test_param_sweep();
    int img5[6][8];
    int r = 0, c = 0, idx = 0, cyc = 0, wins = 0, er = 0, ec = 0;
    bit acc, xfer, pend = 0;
    logic [249:0] ew = '0;
    while ((idx < 48 || pend) && cyc < 1000) begin
      b_in_valid  = (idx < 48) && ($urandom_range(0, 4) != 0);
      b_pixel     = 10'(idx);
      b_sof       = b_in_valid && idx == 0;
      b_out_ready = 1'b1;
      #1;
      acc  = b_in_valid && b_in_ready;
      xfer = b_out_valid && b_out_ready;
      if (xfer) begin
        total++;
        if (!pend || b_window !== ew || b_row !== 3'(er) || b_col !== 3'(ec))
          $display("FAIL window_b: got %h r%0d c%0d exp %h r%0d c%0d", b_window, b_row, b_col, ew, er, ec);
        else passed++;
        wins++;
        pend = 0;
      end
      if (acc) begin
        img5[r][c] = idx;
        if (r >= 4 && c >= 4) begin
          ew = '0;
          for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
              ew[(rr*5+cc)*10 +: 10] = 10'(img5[r-4+rr][c-4+cc]);
          er = r; ec = c; pend = 1;
        end
        c++;
        if (c == 8) begin c = 0; r = (r + 1) % 6; end
        idx++;
      end
      @(negedge clk);
      cyc++;
      total++;
      if (b_out_valid !== pend) $display("FAIL out_valid_b: got %b exp %b", b_out_valid, pend);
      else passed++;
    end
    b_in_valid = 1'b0; b_sof = 1'b0;
    total++;
    if (wins !== 8) $display("FAIL sweep_count: got %0d exp 8", wins);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_sof();
    test_random();
    test_mid_reset();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Parametrised successor to the fixed 3x3 pixel concatenator in the edge-detection datapath.
- Accepts a raster-order pixel stream and keeps K-1 line buffers of IMG_W pixels.
- Emits a full KxK window for every pixel position whose window lies entirely inside the image.
- Sits between the pixel input interface and the Sobel/convolution stage, with valid/ready backpressure on both sides.

Parameters:
- PIX_W, 8: bits per pixel.
- IMG_W, 640: pixels per line. Must be >= K.
- IMG_H, 480: lines per frame. Must be >= K.
- K, 3: window side. Odd, 3..7.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous and active-high (1 = reset), sampled on rising clk.
- sof  in  1  start of frame; qualified by in_valid&&in_ready; that pixel is (row 0, col 0).
- in_valid  in  1  pixel present.
- in_ready  out  1  block can accept a pixel this cycle.
- pixel  in  PIX_W  input pixel.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- window  out  K*K*PIX_W  flattened window. Index i = r*K+c occupies bits [(i+1)*PIX_W-1 : i*PIX_W]; r=0 is the oldest line, c=0 the oldest column. For K=3, i=0..8 maps to s1..s9.
- col  out  log2(IMG_W)  column of the window's bottom-right pixel.
- row  out  log2(IMG_H)  row of the window's bottom-right pixel.
- frame_done  out  1  one-cycle pulse when pixel (IMG_H-1, IMG_W-1) is accepted.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - out_valid=0, window=0, col=0, row=0, frame_done=0.
  - Internal column/row counters = 0.
  - Line-buffer contents are don't-care; validity is gated by counters, so no buffer clear is needed.
- Handshake:
  - in_ready = out_ready || !out_valid, so backpressure is combinational from out_ready.
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - window, col and row are held stable while out_valid && !out_ready.
- On accept:
  - Pixel is written into the K x K shift register's bottom row, newest column.
  - Pixel is written into the line buffer at the current column.
  - Upper rows are shifted in from the line buffers read at the same column.
  - Column counter increments.
- Column wrap: at IMG_W-1, col goes to 0 and row increments.
- Row wrap: at (IMG_H-1, IMG_W-1), row goes to 0, col goes to 0, and frame_done pulses the next cycle.
- Window valid: on the cycle after an accept whose pixel is at (r, c) with r >= K-1 and c >= K-1:
  - out_valid=1, window holds the KxK neighbourhood ending at (r, c), col=c, row=r.
  - Latency is 1 cycle from accept to out_valid.
- Border pixels (r < K-1 or c < K-1):
  - Accepted and buffered, but produce no window.
  - out_valid falls after a transfer if no new valid window arrives.
- Horizontal continuity: the window never spans a line wrap. Validity is recomputed from the column counter, so stale columns from the previous line are never emitted.
- sof handling:
  - sof on an accepted pixel forces the counters to (0, 0) for that pixel, even mid-frame (resync).
  - Any pending window is still transferred normally.
  - After sof, no window appears until row K-1, col K-1 of the new frame.
- Simultaneous transfer and accept: the new window replaces the old one in the same cycle, giving no bubble.
- Reset mid-frame: all state returns to reset values. The first pixel after reset is treated as (0, 0) whether or not sof is asserted.

Decomposition:
- Package sliding_window_pkg:
  - default PIX_W/K constants;
  - pixel_t typedef;
  - function win_idx(r, c) = r*K+c;
  - clog2-based width constants for col/row.
- Sub-module line_buffer (params PIX_W, IMG_W):
  - single-port-read/single-write array, read-before-write at the same address, 1 write per accept;
  - K-1 instances, chained.
- Top contains the counters, valid logic, window shift registers and handshake.

Test Plan:
- Basic window: K=3, IMG_W=4, IMG_H=4, PIX_W=8, pixels 0..15 streamed with out_ready=1.
  - Accept of pixel 10 -> next cycle window={0,1,2,4,5,6,8,9,10}, row=2, col=2.
  - Pixel 11 -> window={1,2,3,5,6,7,9,10,11}.
  - Pixels 12 and 13 -> no out_valid.
  - Pixel 14 -> window={4,5,6,8,9,10,12,13,14}.
  - Total of 4 windows per frame.
- Backpressure: same stream with out_ready=0 for 5 cycles after the first window.
  - in_ready=0 and window/col/row stable.
  - Pixel 11 is not consumed until out_ready=1.
  - No window is lost or duplicated.
- Frame wrap: stream two back-to-back frames (values 0..15, then 100..115).
  - frame_done pulses once after pixel 15.
  - The first window of frame 2 is {100,101,102,104,105,106,108,109,110}.
- Mid-frame sof: assert sof on pixel 6 of a frame.
  - Counters restart at (0, 0).
  - The first subsequent window ends at the 11th pixel after sof.
  - No window mixes pre-sof pixels into row 0.
- Mid-operation reset: assert n_rst=1 for 1 cycle after pixel 9.
  - out_valid=0, frame_done=0, row=col=0.
  - Restreaming 0..15 reproduces the basic-window results.
- Parameter sweep: K=5, IMG_W=8, IMG_H=6, PIX_W=10, incrementing pixels.
  - The first window appears after pixel 4*8+4=36 and equals rows 0..4, cols 0..4.
  - 4 windows per row, 8 windows per frame.
